// File: rtl/tp_event_outbuf.sv
// rtl/tp_event_outbuf.sv - whole-event output buffer between tp dout and the readout link
module tp_event_outbuf #(
    parameter int W          = 65,
    parameter int DEPTH_LOG2 = 9,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     din,
    input  logic             din_valid,
    output logic [W-1:0]     dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [CNT_W-1:0] drop_count,
    output logic [CNT_W-1:0] orphan_count,
    output logic             full
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_OCC = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_IN_EVT, S_DROP} state_t;

    state_t              state_q, state_d;
    logic [DEPTH_LOG2:0] wr_q, wr_d, commit_q, commit_d, rd_q, fe_q;
    logic [CNT_W-1:0]    drop_q, orphan_q;
    logic [W-1:0]        ram [DEPTH];
    logic [W-1:0]        rdata_q, dout_q;
    logic                s1_valid_q, dout_valid_q;
    logic                meta, wr_req, overflow, wr_en, drop_inc, orphan_inc;
    logic                pop, s2_load, fetch;

    assign meta     = din[W-1];
    // rd_q advances only on handshake, so prefetched words keep their RAM slots reserved
    assign full     = ((wr_q - rd_q) == FULL_OCC);
    assign wr_req   = din_valid && (((state_q == S_IDLE) && meta) || (state_q == S_IN_EVT));
    assign overflow = wr_req && full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (din_valid) begin
            case (state_q)
                S_IDLE:   if (meta) state_d = overflow ? S_DROP : S_IN_EVT;
                S_IN_EVT: if (meta) state_d = S_IDLE;
                          else if (overflow) state_d = S_DROP;
                S_DROP:   if (meta) state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        wr_en      = wr_req && !full;
        wr_d       = wr_q;
        commit_d   = commit_q;
        drop_inc   = 1'b0;
        orphan_inc = din_valid && (state_q == S_IDLE) && !meta;
        if (overflow) begin
            wr_d     = commit_q;
            drop_inc = 1'b1;
        end else if (wr_en) begin
            wr_d = wr_q + 1'b1;
            if ((state_q == S_IN_EVT) && meta) commit_d = wr_q + 1'b1;
        end
    end

    // Two-stage read pipeline: RAM data register, then output register
    assign pop     = dout_valid_q && dout_ready;
    assign s2_load = s1_valid_q && (!dout_valid_q || pop);
    assign fetch   = (fe_q != commit_q) && (!s1_valid_q || s2_load);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q         <= '0;
            commit_q     <= '0;
            rd_q         <= '0;
            fe_q         <= '0;
            drop_q       <= '0;
            orphan_q     <= '0;
            s1_valid_q   <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
        end else begin
            wr_q       <= wr_d;
            commit_q   <= commit_d;
            if (pop)   rd_q <= rd_q + 1'b1;
            if (fetch) fe_q <= fe_q + 1'b1;
            if (drop_inc && (drop_q != '1))     drop_q   <= drop_q + 1'b1;
            if (orphan_inc && (orphan_q != '1)) orphan_q <= orphan_q + 1'b1;
            s1_valid_q   <= fetch || (s1_valid_q && !s2_load);
            dout_valid_q <= s2_load || (dout_valid_q && !pop);
            if (s2_load) dout_q <= rdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) ram[wr_q[DEPTH_LOG2-1:0]] <= din;
        if (fetch) rdata_q <= ram[fe_q[DEPTH_LOG2-1:0]];
    end

    assign dout         = dout_q;
    assign dout_valid   = dout_valid_q;
    assign drop_count   = drop_q;
    assign orphan_count = orphan_q;
endmodule

// File: tb/tb_tp_event_outbuf.sv
// tb/tb_tp_event_outbuf.sv - directed self-checking bench for tp_event_outbuf
module tb_tp_event_outbuf;
    localparam int W  = 65;
    localparam int DL = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  din = '0;
    logic          din_valid = 1'b0;
    logic          dout_ready = 1'b0;
    logic [W-1:0]  dout;
    logic          dout_valid;
    logic          full;
    logic [CW-1:0] drop_count;
    logic [CW-1:0] orphan_count;

    int passed = 0;
    int total  = 0;
    logic [W-1:0] got[$];
    logic [W-1:0] exp[$];

    always #5 clk = ~clk;

    tp_event_outbuf #(.W(W), .DEPTH_LOG2(DL), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .drop_count(drop_count), .orphan_count(orphan_count), .full(full)
    );

    function automatic logic [W-1:0] mk(input logic m, input logic [63:0] v);
        return {m, v};
    endfunction

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Called at a negedge with inputs already applied; captures the handshake at the next posedge
    task automatic tick();
        logic         stall;
        logic [W-1:0] held;
        stall = dout_valid && !dout_ready;
        held  = dout;
        if (dout_valid && dout_ready) got.push_back(dout);
        @(negedge clk);
        if (stall) chk("stall_hold", {dout_valid, dout}, {1'b1, held});
    endtask

    task automatic send(input logic m, input logic [63:0] v, input bit keep);
        din_valid = 1'b1;
        din       = mk(m, v);
        if (keep) exp.push_back(mk(m, v));
        tick();
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic check_got(input string tag);
        chk({tag, "_count"}, 66'(got.size()), 66'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) chk(tag, got[i], exp[i]);
        got.delete();
        exp.delete();
    endtask

    initial begin
        // reset state
        @(negedge clk);
        chk("rst_dout", dout, '0);
        chk("rst_dout_valid", dout_valid, '0);
        chk("rst_drop", drop_count, '0);
        chk("rst_orphan", orphan_count, '0);
        chk("rst_full", full, '0);
        rst = 1'b1;

        // basic event and header latency
        dout_ready = 1'b1;
        send(1'b1, 64'hA1, 1'b1);
        send(1'b0, 64'h1, 1'b1);
        send(1'b0, 64'h2, 1'b1);
        send(1'b1, 64'hF1, 1'b1);
        din_valid = 1'b0;
        chk("lat_k0", dout_valid, '0);
        tick();
        chk("lat_k1", dout_valid, '0);
        tick();
        chk("lat_k2_hdr", {dout_valid, dout}, {1'b1, mk(1'b1, 64'hA1)});
        idle(6);
        check_got("basic");
        chk("basic_empty", dout_valid, '0);
        chk("basic_drop", drop_count, '0);

        // backpressure
        dout_ready = 1'b0;
        send(1'b1, 64'hA1, 1'b1);
        send(1'b0, 64'h1, 1'b1);
        send(1'b0, 64'h2, 1'b1);
        send(1'b1, 64'hF1, 1'b1);
        idle(10);
        for (int i = 0; i < 8; i++) begin
            dout_ready = ((i % 2) == 0);
            tick();
        end
        dout_ready = 1'b1;
        idle(6);
        check_got("bp");
        chk("bp_empty", dout_valid, '0);

        // overflow drop: 10-word event fits, 12-word event overflows on its 7th word
        dout_ready = 1'b0;
        send(1'b1, 64'h100, 1'b1);
        for (int i = 1; i <= 8; i++) send(1'b0, 64'h100 + 64'(i), 1'b1);
        send(1'b1, 64'h1FF, 1'b1);
        send(1'b1, 64'h200, 1'b0);
        for (int i = 1; i <= 4; i++) send(1'b0, 64'h200 + 64'(i), 1'b0);
        chk("ovf_full_w5", full, '0);
        send(1'b0, 64'h205, 1'b0);
        chk("ovf_full_w6", full, 66'd1);
        chk("ovf_drop_w6", drop_count, '0);
        send(1'b0, 64'h206, 1'b0);
        chk("ovf_drop_w7", drop_count, 66'd1);
        chk("ovf_full_w7", full, '0);
        for (int i = 7; i <= 10; i++) send(1'b0, 64'h200 + 64'(i), 1'b0);
        send(1'b1, 64'h2FF, 1'b0);
        chk("ovf_drop_end", drop_count, 66'd1);
        dout_ready = 1'b1;
        idle(14);
        check_got("ovf_first");
        send(1'b1, 64'h300, 1'b1);
        send(1'b0, 64'h301, 1'b1);
        send(1'b1, 64'h3FF, 1'b1);
        idle(6);
        check_got("ovf_next");

        // orphans
        for (int i = 0; i < 3; i++) send(1'b0, 64'h30 + 64'(i), 1'b0);
        chk("orphan_cnt", orphan_count, 66'd3);
        send(1'b1, 64'h40, 1'b1);
        send(1'b0, 64'h41, 1'b1);
        send(1'b1, 64'h4F, 1'b1);
        idle(6);
        check_got("orphan_evt");
        chk("orphan_cnt_after", orphan_count, 66'd3);

        // reset mid-event while event 1 is being read
        send(1'b1, 64'h50, 1'b0);
        for (int i = 1; i <= 4; i++) send(1'b0, 64'h50 + 64'(i), 1'b0);
        send(1'b1, 64'h5F, 1'b0);
        send(1'b1, 64'h60, 1'b0);
        send(1'b0, 64'h61, 1'b0);
        send(1'b0, 64'h62, 1'b0);
        chk("rst_mid_reading", dout_valid, 66'd1);
        rst = 1'b0;
        din_valid = 1'b0;
        #1;
        chk("rst_async_dout", dout, '0);
        chk("rst_async_valid", dout_valid, '0);
        chk("rst_async_drop", drop_count, '0);
        chk("rst_async_orphan", orphan_count, '0);
        chk("rst_async_full", full, '0);
        got.delete();
        exp.delete();
        tick();
        rst = 1'b1;
        send(1'b1, 64'h70, 1'b1);
        send(1'b0, 64'h71, 1'b1);
        send(1'b1, 64'h7F, 1'b1);
        idle(6);
        check_got("post_rst");

        // counter saturation behind a completely full buffer
        dout_ready = 1'b0;
        send(1'b1, 64'h600, 1'b1);
        for (int i = 1; i <= 14; i++) send(1'b0, 64'h600 + 64'(i), 1'b1);
        send(1'b1, 64'h6FF, 1'b1);
        chk("sat_full", full, 66'd1);
        send(1'b1, 64'h700, 1'b0);
        chk("sat_drop1", drop_count, 66'd1);
        send(1'b1, 64'h7FF, 1'b0);
        for (int i = 1; i < 20; i++) begin
            send(1'b1, 64'h700, 1'b0);
            send(1'b1, 64'h7FF, 1'b0);
        end
        chk("sat_drop20", drop_count, 66'hF);
        chk("sat_full_kept", full, 66'd1);
        dout_ready = 1'b1;
        idle(20);
        check_got("sat_first");
        send(1'b1, 64'h800, 1'b1);
        send(1'b1, 64'h8FF, 1'b1);
        idle(6);
        check_got("sat_evt");
        chk("sat_drop_end", drop_count, 66'hF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
